dfi_upd_ctrl: RTL and testbench
===============================

DFI_UPD_CTRL -- requirements
Module: dfi_upd_ctrl

Interface
REQ-001 SHALL have parameter TPHYUPD_RESP, default 16: max cycles from phyupd_req sampled high to phyupd_ack high.
REQ-002 SHALL have parameter TCTRLUPD_MIN, default 4: min cycles ctrlupd_req stays high once asserted.
REQ-003 SHALL have parameter TCTRLUPD_MAX, default 64: cycles without ctrlupd_ack before ctrlupd_req is abandoned.
REQ-004 SHALL have port clock  in  1: single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port dfi_idle  in  1: high when no command, wrdata_en or rddata_en is in flight.
REQ-007 SHALL have port init_start  in  1: DFI init in progress; no handshake may start.
REQ-008 SHALL have port ctrlupd_start  in  1: one-cycle host request for a controller update.
REQ-009 SHALL have port phyupd_req  in  1: PHY update request.
REQ-010 SHALL have port phyupd_type  in  2: PHY update type, valid while phyupd_req is high.
REQ-011 SHALL have port ctrlupd_ack  in  1: PHY acknowledge of ctrlupd_req.
REQ-012 SHALL have port phyupd_ack  out  1: acknowledge to PHY.
REQ-013 SHALL have port ctrlupd_req  out  1: controller update request to PHY.
REQ-014 SHALL have port cmd_block  out  1: stall to the command/read/write path.
REQ-015 SHALL have port upd_type_q  out  2: phyupd_type captured at acknowledge.
REQ-016 SHALL have port ctrlupd_done  out  1: one-cycle pulse when a controller update completes or is abandoned.
REQ-017 SHALL have port resp_err  out  1: sticky flag; PHY ack deadline missed.

Function
REQ-018 SHALL drive all outputs from registers.
REQ-019 SHALL implement FSM states IDLE, PHY_DRAIN, PHY_ACK, CTRL_DRAIN, CTRL_REQ, CTRL_WAIT_ACK_LOW.
REQ-020 SHALL, in IDLE with init_start low and phyupd_req high, go to PHY_DRAIN; this takes priority over a pending ctrlupd.
REQ-021 SHALL latch ctrlupd_start into a pending bit in any state; a second start while pending is absorbed.
REQ-022 SHALL, in IDLE with init_start low, phyupd_req low and pending set, go to CTRL_DRAIN.
REQ-023 SHALL assert cmd_block in every state except IDLE.
REQ-024 SHALL, in PHY_DRAIN, count cycles from entry; when dfi_idle is high, go to PHY_ACK and register phyupd_ack=1 and upd_type_q=phyupd_type.
REQ-025 SHALL set resp_err when the PHY_DRAIN count reaches TPHYUPD_RESP-1 without dfi_idle; the block still acks once dfi_idle rises.
REQ-026 SHALL return from PHY_DRAIN to IDLE without acking if phyupd_req drops before dfi_idle.
REQ-027 SHALL hold phyupd_ack high in PHY_ACK while phyupd_req is high.
REQ-028 SHALL clear phyupd_ack on the cycle after phyupd_req is sampled low, then return to IDLE.
REQ-029 SHALL, in CTRL_DRAIN, go to CTRL_REQ when dfi_idle is high and phyupd_req is low.
REQ-030 SHALL yield to phyupd_req in CTRL_DRAIN: go to PHY_DRAIN and keep pending set.
REQ-031 SHALL, on entering CTRL_REQ, assert ctrlupd_req, clear pending and start a counter at 0.
REQ-032 SHALL keep ctrlupd_req high for at least TCTRLUPD_MIN cycles.
REQ-033 SHALL, once ctrlupd_ack is seen, keep ctrlupd_req high until the minimum is met, then drop it and go to CTRL_WAIT_ACK_LOW.
REQ-034 SHALL, if no ack is seen by count TCTRLUPD_MAX-1, drop ctrlupd_req, pulse ctrlupd_done and return to IDLE.
REQ-035 SHALL, in CTRL_WAIT_ACK_LOW, wait for ctrlupd_ack low, then pulse ctrlupd_done and go to IDLE.
REQ-036 SHALL ignore phyupd_req during CTRL_REQ and CTRL_WAIT_ACK_LOW; it is serviced from IDLE afterwards.
REQ-037 SHALL never have phyupd_ack and ctrlupd_req high in the same cycle.
REQ-038 SHALL never assert phyupd_ack or raise ctrlupd_req while init_start is high; an in-progress handshake completes normally.
REQ-039 SHALL saturate counters at their terminal value; they never wrap.

Reset
REQ-040 SHALL, on reset high at a clock edge, set state IDLE and clear pending.
REQ-041 SHALL, on reset, clear phyupd_ack, ctrlupd_req, cmd_block, ctrlupd_done, resp_err and upd_type_q to 0 on that edge, including mid-handshake.

Verification
REQ-042 SHALL check: dfi_idle=1, phyupd_req rises at cycle 0 with type 2'b01 -> cmd_block=1 at cycle 1, phyupd_ack=1 and upd_type_q=2'b01 at cycle 2; req low at cycle 10 -> ack low at cycle 11, cmd_block low at cycle 12.
REQ-043 SHALL check: dfi_idle held low 20 cycles after phyupd_req -> resp_err=1 at drain count 15; ack follows dfi_idle rise by 1 cycle.
REQ-044 SHALL check: ctrlupd_start pulse, dfi_idle=1, ctrlupd_ack returned after 1 cycle and dropped 2 cycles after req falls -> ctrlupd_req high exactly 4 cycles, then ctrlupd_done pulse.
REQ-045 SHALL check: ctrlupd_start with no ctrlupd_ack -> ctrlupd_req high 64 cycles, then ctrlupd_done pulse, state IDLE.
REQ-046 SHALL check: ctrlupd_start and phyupd_req in the same cycle -> PHY handshake completes first, then ctrlupd_req rises; no cycle has phyupd_ack & ctrlupd_req.
REQ-047 SHALL check: reset asserted during PHY_ACK -> all outputs 0 next edge; init_start=1 with phyupd_req=1 -> phyupd_ack stays 0.

Source files
------------

// File: rtl/dfi_upd_ctrl.sv
// DFI update controller: arbitrates PHY-initiated (phyupd) and
// controller-initiated (ctrlupd) update handshakes, stalls the command path
// while an update is being negotiated and reports a sticky error when the
// PHY acknowledge deadline is missed.
module dfi_upd_ctrl #(
    parameter int TPHYUPD_RESP = 16,
    parameter int TCTRLUPD_MIN = 4,
    parameter int TCTRLUPD_MAX = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dfi_idle,
    input  logic       init_start,
    input  logic       ctrlupd_start,
    input  logic       phyupd_req,
    input  logic [1:0] phyupd_type,
    input  logic       ctrlupd_ack,
    output logic       phyupd_ack,
    output logic       ctrlupd_req,
    output logic       cmd_block,
    output logic [1:0] upd_type_q,
    output logic       ctrlupd_done,
    output logic       resp_err
);

    localparam int PW = (TPHYUPD_RESP > 2) ? $clog2(TPHYUPD_RESP) : 1;
    localparam int CW = (TCTRLUPD_MAX > 2) ? $clog2(TCTRLUPD_MAX) : 1;

    // Drain counter terminal value, and the count at which the PHY deadline
    // is declared missed (the flag rises together with the counter reaching
    // its terminal value).
    localparam logic [PW-1:0] PHY_LAST   = PW'(TPHYUPD_RESP - 1);
    localparam logic [PW-1:0] PHY_ERR_AT = PW'(TPHYUPD_RESP - 2);
    // ctrlupd_req may drop on the edge where the counter holds MIN-1, which
    // gives exactly TCTRLUPD_MIN visible high cycles; abandon at MAX-1.
    localparam logic [CW-1:0] CTRL_MIN_LAST = CW'(TCTRLUPD_MIN - 1);
    localparam logic [CW-1:0] CTRL_LAST     = CW'(TCTRLUPD_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PHY_DRAIN,
        S_PHY_ACK,
        S_CTRL_DRAIN,
        S_CTRL_REQ,
        S_CTRL_WAIT_ACK_LOW
    } state_t;

    state_t          state_reg;
    logic            pending_reg;
    logic            ack_seen_reg;
    logic [PW-1:0]   phy_cnt_reg;
    logic [CW-1:0]   ctrl_cnt_reg;
    logic            phyupd_ack_reg;
    logic            ctrlupd_req_reg;
    logic            cmd_block_reg;
    logic [1:0]      upd_type_reg;
    logic            ctrlupd_done_reg;
    logic            resp_err_reg;

    assign phyupd_ack   = phyupd_ack_reg;
    assign ctrlupd_req  = ctrlupd_req_reg;
    assign cmd_block    = cmd_block_reg;
    assign upd_type_q   = upd_type_reg;
    assign ctrlupd_done = ctrlupd_done_reg;
    assign resp_err     = resp_err_reg;

    // Handshake FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            pending_reg      <= 1'b0;
            ack_seen_reg     <= 1'b0;
            phy_cnt_reg      <= '0;
            ctrl_cnt_reg     <= '0;
            phyupd_ack_reg   <= 1'b0;
            ctrlupd_req_reg  <= 1'b0;
            cmd_block_reg    <= 1'b0;
            upd_type_reg     <= 2'b00;
            ctrlupd_done_reg <= 1'b0;
            resp_err_reg     <= 1'b0;
        end else begin
            ctrlupd_done_reg <= 1'b0;
            // Host requests are remembered until the update actually starts;
            // repeated starts collapse into the one pending request.
            if (ctrlupd_start) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    // PHY requests win over a pending controller update.
                    if (!init_start && phyupd_req) begin
                        state_reg     <= S_PHY_DRAIN;
                        cmd_block_reg <= 1'b1;
                        phy_cnt_reg   <= '0;
                    end else if (!init_start && pending_reg) begin
                        state_reg     <= S_CTRL_DRAIN;
                        cmd_block_reg <= 1'b1;
                    end
                end

                S_PHY_DRAIN: begin
                    if (!phyupd_req) begin
                        // PHY withdrew before traffic drained: no ack.
                        state_reg     <= S_IDLE;
                        cmd_block_reg <= 1'b0;
                    end else if (dfi_idle && !init_start) begin
                        state_reg      <= S_PHY_ACK;
                        phyupd_ack_reg <= 1'b1;
                        upd_type_reg   <= phyupd_type;
                    end else begin
                        if (phy_cnt_reg != PHY_LAST) begin
                            phy_cnt_reg <= phy_cnt_reg + PW'(1);
                        end
                        if (phy_cnt_reg >= PHY_ERR_AT) begin
                            resp_err_reg <= 1'b1;
                        end
                    end
                end

                S_PHY_ACK: begin
                    // Drop ack first; leave the stall up for one more cycle
                    // so the path is only released after ack is seen low.
                    if (phyupd_ack_reg) begin
                        if (!phyupd_req) begin
                            phyupd_ack_reg <= 1'b0;
                        end
                    end else begin
                        state_reg     <= S_IDLE;
                        cmd_block_reg <= 1'b0;
                    end
                end

                S_CTRL_DRAIN: begin
                    if (phyupd_req) begin
                        // Yield to the PHY; pending stays set for later.
                        state_reg   <= S_PHY_DRAIN;
                        phy_cnt_reg <= '0;
                    end else if (dfi_idle && !init_start) begin
                        state_reg       <= S_CTRL_REQ;
                        ctrlupd_req_reg <= 1'b1;
                        ctrl_cnt_reg    <= '0;
                        ack_seen_reg    <= 1'b0;
                        pending_reg     <= 1'b0;
                    end
                end

                S_CTRL_REQ: begin
                    if (ctrlupd_ack) begin
                        ack_seen_reg <= 1'b1;
                    end
                    if ((ack_seen_reg || ctrlupd_ack) && (ctrl_cnt_reg >= CTRL_MIN_LAST)) begin
                        ctrlupd_req_reg <= 1'b0;
                        state_reg       <= S_CTRL_WAIT_ACK_LOW;
                    end else if (ctrl_cnt_reg >= CTRL_LAST) begin
                        // PHY never answered: abandon the request.
                        ctrlupd_req_reg  <= 1'b0;
                        ctrlupd_done_reg <= 1'b1;
                        cmd_block_reg    <= 1'b0;
                        state_reg        <= S_IDLE;
                    end else begin
                        ctrl_cnt_reg <= ctrl_cnt_reg + CW'(1);
                    end
                end

                S_CTRL_WAIT_ACK_LOW: begin
                    if (!ctrlupd_ack) begin
                        ctrlupd_done_reg <= 1'b1;
                        cmd_block_reg    <= 1'b0;
                        state_reg        <= S_IDLE;
                    end
                end

                default: begin
                    state_reg       <= S_IDLE;
                    cmd_block_reg   <= 1'b0;
                    phyupd_ack_reg  <= 1'b0;
                    ctrlupd_req_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfi_upd_ctrl.sv
// Scoreboard bench for dfi_upd_ctrl: each cycle the expected output vector
// for the coming edge is queued while inputs are driven, then popped and
// compared once the edge has happened.
module tb_dfi_upd_ctrl;

    logic       clock;
    logic       reset;
    logic       dfi_idle;
    logic       init_start;
    logic       ctrlupd_start;
    logic       phyupd_req;
    logic [1:0] phyupd_type;
    logic       ctrlupd_ack;
    logic       phyupd_ack;
    logic       ctrlupd_req;
    logic       cmd_block;
    logic [1:0] upd_type_q;
    logic       ctrlupd_done;
    logic       resp_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] obs;
    assign obs = {phyupd_ack, ctrlupd_req, cmd_block, upd_type_q, ctrlupd_done, resp_err};

    dfi_upd_ctrl #(
        .TPHYUPD_RESP(16),
        .TCTRLUPD_MIN(4),
        .TCTRLUPD_MAX(64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dfi_idle     (dfi_idle),
        .init_start   (init_start),
        .ctrlupd_start(ctrlupd_start),
        .phyupd_req   (phyupd_req),
        .phyupd_type  (phyupd_type),
        .ctrlupd_ack  (ctrlupd_ack),
        .phyupd_ack   (phyupd_ack),
        .ctrlupd_req  (ctrlupd_req),
        .cmd_block    (cmd_block),
        .upd_type_q   (upd_type_q),
        .ctrlupd_done (ctrlupd_done),
        .resp_err     (resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Vector order: {phyupd_ack, ctrlupd_req, cmd_block, upd_type_q, ctrlupd_done, resp_err}
    function automatic logic [6:0] mk(bit a, bit cr, bit cb, logic [1:0] t, bit d, bit e);
        return {a, cr, cb, t, d, e};
    endfunction

    task automatic check_eq(input string tag, input logic [6:0] act, input logic [6:0] exp_v);
        checks_cnt++;
        if (act !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %b expected %b (ack,creq,blk,type[2],done,err) t=%0t",
                     tag, act, exp_v, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic [6:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    // Advance one edge and compare against the oldest queued expectation.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            errors_cnt++;
            $display("FAIL underflow: got %b expected <queued value> t=%0t", obs, $time);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, obs, e.v);
        end
    endtask

    task automatic idle_inputs();
        dfi_idle      = 1'b1;
        init_start    = 1'b0;
        ctrlupd_start = 1'b0;
        phyupd_req    = 1'b0;
        phyupd_type   = 2'b00;
        ctrlupd_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        push_exp("reset", 7'b0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        int c;
        reset = 1'b1;
        idle_inputs();

        // A: basic PHY update with the bus already idle.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            c = k + 1;
            phyupd_req  = (k < 10);
            phyupd_type = 2'b01;
            push_exp("phy_basic",
                     mk(c >= 2 && c <= 10, 1'b0, c <= 11, (c >= 2) ? 2'b01 : 2'b00, 1'b0, 1'b0));
            step();
        end
        $display("txn phy_basic: ack window cycles 2..10");

        // B: drain stalls for 20 cycles, deadline missed at drain count 15.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            c = k + 1;
            dfi_idle    = (k >= 20);
            phyupd_req  = (k < 25);
            phyupd_type = 2'b10;
            push_exp("phy_late",
                     mk(c >= 21 && c <= 25, 1'b0, c <= 26, (c >= 21) ? 2'b10 : 2'b00, 1'b0, c >= 16));
            step();
        end
        $display("txn phy_late: resp_err from cycle 16, ack from cycle 21");

        // Reset must clear the sticky error.
        do_reset();

        // C: controller update, ack after 1 cycle, ack drops 2 cycles after req.
        for (int k = 0; k < 13; k++) begin
            c = k + 1;
            ctrlupd_start = (k == 0);
            ctrlupd_ack   = (k >= 4 && k <= 8);
            push_exp("ctrl_ack",
                     mk(1'b0, c >= 3 && c <= 6, c >= 2 && c <= 9, 2'b00, c == 10, 1'b0));
            step();
        end
        $display("txn ctrl_ack: ctrlupd_req cycles 3..6, done at 10");

        // D: controller update that the PHY never acknowledges.
        do_reset();
        for (int k = 0; k < 70; k++) begin
            c = k + 1;
            ctrlupd_start = (k == 0);
            push_exp("ctrl_timeout",
                     mk(1'b0, c >= 3 && c <= 66, c >= 2 && c <= 66, 2'b00, c == 67, 1'b0));
            step();
        end
        $display("txn ctrl_timeout: ctrlupd_req cycles 3..66, done at 67");

        // E: simultaneous requests; PHY first, then the pending ctrlupd.
        do_reset();
        for (int k = 0; k < 19; k++) begin
            c = k + 1;
            ctrlupd_start = (k == 0);
            phyupd_req    = (k < 5);
            phyupd_type   = 2'b11;
            ctrlupd_ack   = (k >= 10 && k <= 14);
            push_exp("arbitrate",
                     mk(c >= 2 && c <= 5, c >= 9 && c <= 12,
                        (c >= 1 && c <= 6) || (c >= 8 && c <= 15),
                        (c >= 2) ? 2'b11 : 2'b00, c == 16, 1'b0));
            step();
            if (phyupd_ack && ctrlupd_req) begin
                check_eq("exclusive", {6'b0, 1'b1}, 7'b0);
            end
        end
        $display("txn arbitrate: phy ack 2..5, ctrlupd_req 9..12, done at 16");

        // F: reset in PHY_ACK, then init_start blocks a new PHY request.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            c = k + 1;
            reset       = (k == 3);
            phyupd_req  = 1'b1;
            phyupd_type = 2'b01;
            init_start  = (k >= 4);
            if (c == 1) begin
                push_exp("reset_mid", mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0));
            end else if (c <= 3) begin
                push_exp("reset_mid", mk(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0));
            end else begin
                push_exp("init_block", 7'b0);
            end
            step();
        end
        reset = 1'b0;
        $display("txn reset_mid: outputs cleared at cycle 4, init_start held off ack");

        // G: PHY withdraws before the bus drains; no ack.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            c = k + 1;
            dfi_idle    = 1'b0;
            phyupd_req  = (k < 3);
            phyupd_type = 2'b10;
            push_exp("phy_abort", mk(1'b0, 1'b0, c <= 3, 2'b00, 1'b0, 1'b0));
            step();
        end
        $display("txn phy_abort: stall cycles 1..3, no ack");

        if (exp_q.size() != 0) begin
            errors_cnt++;
            $display("FAIL leftover: got %0d queued entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
